instr_fetch_unit: RTL and testbench

Instruction fetch controller that consumes the current PC, fetches the instruction from instruction memory over a valid/ready request plus response-valid interface, and presents it to decode with a valid/ready handshake. It drives the program counter's `pc_next`/`enable` inputs, computing sequential `pc+4` or a redirect target. It sits between the program counter register, instruction memory and the decode stage. One request is outstanding at a time.

---
 rtl/fetch_pkg.sv | 16 +
 rtl/instr_fetch_unit.sv | 129 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state type and the
// instruction size/alignment constants used to step and validate the PC.
package fetch_pkg;

  typedef enum logic [2:0] {
    REQ   = 3'd0,
    WAIT  = 3'd1,
    DRAIN = 3'd2,
    HOLD  = 3'd3,
    FAULT = 3'd4
  } fetch_state_t;

  localparam int unsigned INSTR_BYTES = 4;
  localparam logic [1:0]  ALIGN_MASK  = 2'b11;

endpackage

// File: rtl/instr_fetch_unit.sv
// Instruction fetch controller. Issues one instruction-memory request at a
// time for the current PC, holds the returned instruction for decode and
// steers the external PC register (sequential pc+4 or redirect target).
//
// Ports:
//   clk, reset                       clock, asynchronous active-high reset
//   pc                               current PC from the external PC register
//   pc_next, pc_enable               next PC value and its one-cycle load strobe
//   imem_req_valid/ready/addr        fetch request channel (addr always == pc)
//   imem_rsp_valid/data              fetch response, single-cycle valid
//   instr_valid/ready, instr,
//   instr_pc                         held instruction and its PC towards decode
//   redirect_valid/target            branch/jump/trap redirect, single cycle
//   fetch_fault                      misaligned fetch PC detected
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_next,
  output logic            pc_enable,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            instr_valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  input  logic            instr_ready,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic            fetch_fault
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] instr_q, instr_pc_q;
  logic            instr_valid_q, fetch_fault_q;
  logic            capture;
  logic            misaligned;

  assign misaligned    = (pc[1:0] & ALIGN_MASK) != 2'b00;
  assign imem_req_addr = pc;

  always_comb begin
    state_d        = state_q;
    pc_enable      = 1'b0;
    pc_next        = pc + XLEN'(INSTR_BYTES);
    imem_req_valid = 1'b0;
    capture        = 1'b0;

    // A redirect always loads the PC, whatever the state.
    if (redirect_valid) begin
      pc_enable = 1'b1;
      pc_next   = redirect_target;
    end

    unique case (state_q)
      REQ: begin
        if (redirect_valid) begin
          state_d = REQ;
        end else if (misaligned) begin
          state_d = FAULT;
        end else begin
          imem_req_valid = 1'b1;
          if (imem_req_ready) state_d = WAIT;
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          // The outstanding response must still be swallowed unless it is here now.
          state_d = imem_rsp_valid ? REQ : DRAIN;
        end else if (imem_rsp_valid) begin
          capture = 1'b1;
          state_d = HOLD;
        end
      end
      DRAIN: begin
        // The stale response retires the drain even if a new redirect arrives
        // with it; otherwise nothing would ever release this state.
        if (imem_rsp_valid) state_d = REQ;
      end
      HOLD: begin
        if (redirect_valid) begin
          state_d = REQ;
        end else if (instr_ready) begin
          pc_enable = 1'b1;
          state_d   = REQ;
        end
      end
      FAULT: begin
        if (redirect_valid) state_d = REQ;
      end
      default: state_d = REQ;
    endcase

    if (reset) begin
      pc_enable      = 1'b0;
      imem_req_valid = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= REQ;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
      fetch_fault_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      instr_valid_q <= (state_d == HOLD);
      fetch_fault_q <= (state_d == FAULT);
      if (capture) begin
        instr_q    <= imem_rsp_data;
        instr_pc_q <= pc;
      end
    end
  end

  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = instr_valid_q;
  assign fetch_fault = fetch_fault_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios followed by randomized traffic,
// all checked against a transaction-level model of the fetch pipeline plus a
// bench-side PC register and instruction memory.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic        pc_enable;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        fetch_fault;

  instr_fetch_unit #(.XLEN(32)) dut (
    .clk             (clk),
    .reset           (reset),
    .pc              (pc),
    .pc_next         (pc_next),
    .pc_enable       (pc_enable),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_rsp_valid  (imem_rsp_valid),
    .imem_rsp_data   (imem_rsp_data),
    .instr_valid     (instr_valid),
    .instr           (instr),
    .instr_pc        (instr_pc),
    .instr_ready     (instr_ready),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .fetch_fault     (fetch_fault)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Stimulus knobs (used when rnd == 0)
  bit          rnd = 1'b0;
  bit          k_ready = 1'b1;
  int          k_lat = 1;
  bit          k_ir = 1'b1;
  bit          k_redir = 1'b0;
  logic [31:0] k_target = '0;

  // Memory model
  bit          mem_busy = 1'b0;
  int          mem_wait = 0;
  logic [31:0] mem_addr = '0;

  // Transaction-level reference model
  bit          m_out = 1'b0, m_cancel = 1'b0, m_hold = 1'b0, m_fault = 1'b0;
  logic [31:0] m_addr = '0, m_instr = '0, m_ipc = '0;

  // Values to present in the next cycle
  logic [31:0] pc_n = '0;
  bit          n_rsp = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Compare DUT against the model for the current cycle, then advance the model,
  // the memory and the PC register to what they will be after the next edge.
  task automatic model_cycle();
    logic        exp_idle, exp_rv, exp_en, hs, acc, got;
    logic [31:0] exp_nx;
    exp_idle = !m_out && !m_hold && !m_fault;
    exp_rv   = exp_idle && (pc[1:0] == 2'b00) && !redirect_valid;
    check_eq("req_valid", imem_req_valid, exp_rv);
    if (imem_req_valid) check_eq("req_addr", imem_req_addr, pc);
    check_eq("instr_valid", instr_valid, m_hold);
    check_eq("fetch_fault", fetch_fault, m_fault);
    if (m_hold) begin
      check_eq("instr", instr, m_instr);
      check_eq("instr_pc", instr_pc, m_ipc);
    end
    hs     = m_hold && instr_ready;
    exp_en = redirect_valid || hs;
    check_eq("pc_enable", pc_enable, exp_en);
    if (exp_en) begin
      exp_nx = redirect_valid ? redirect_target : pc + 32'd4;
      check_eq("pc_next", pc_next, exp_nx);
    end
    acc = imem_req_valid && imem_req_ready;

    if (redirect_valid) begin
      m_hold  = 1'b0;
      m_fault = 1'b0;
      if (m_out) begin
        if (imem_rsp_valid) begin
          m_out    = 1'b0;
          m_cancel = 1'b0;
        end else begin
          m_cancel = 1'b1;
        end
      end
    end else begin
      got = m_out && imem_rsp_valid && !m_cancel;
      if (m_out && imem_rsp_valid) begin
        m_out    = 1'b0;
        m_cancel = 1'b0;
      end
      if (hs) m_hold = 1'b0;
      if (got) begin
        m_hold  = 1'b1;
        m_instr = mem_word(m_addr);
        m_ipc   = m_addr;
      end
      if (exp_idle && pc[1:0] != 2'b00) m_fault = 1'b1;
    end
    if (acc) begin
      m_out    = 1'b1;
      m_cancel = 1'b0;
      m_addr   = pc;
    end

    if (imem_rsp_valid) mem_busy = 1'b0;
    if (acc) begin
      mem_busy = 1'b1;
      mem_addr = imem_req_addr;
      mem_wait = rnd ? int'($urandom_range(1, 3)) : k_lat;
    end
    n_rsp = 1'b0;
    if (mem_busy) begin
      mem_wait--;
      if (mem_wait == 0) n_rsp = 1'b1;
    end
    pc_n = pc_enable ? pc_next : pc;
  endtask

  task automatic apply_inputs();
    pc             = pc_n;
    imem_rsp_valid = n_rsp;
    imem_rsp_data  = n_rsp ? mem_word(mem_addr) : $urandom;
    if (rnd) begin
      imem_req_ready = ($urandom_range(0, 2) != 0);
      instr_ready    = ($urandom_range(0, 2) != 0);
      redirect_valid = ($urandom_range(0, 11) == 0);
      redirect_target = $urandom;
      if ($urandom_range(0, 5) != 0) redirect_target[1:0] = 2'b00;
    end else begin
      imem_req_ready  = k_ready;
      instr_ready     = k_ir;
      redirect_valid  = k_redir;
      redirect_target = k_redir ? k_target : $urandom;
      k_redir         = 1'b0;
    end
  endtask

  task automatic step();
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    #1;
    apply_inputs();
    #1;
  endtask

  task automatic clear_models();
    mem_busy = 1'b0; mem_wait = 0; n_rsp = 1'b0;
    m_out = 1'b0; m_cancel = 1'b0; m_hold = 1'b0; m_fault = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    pc = '0; pc_n = '0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    instr_ready = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_pc_enable", pc_enable, 0);
    check_eq("rst_req_valid", imem_req_valid, 0);
    check_eq("rst_instr_valid", instr_valid, 0);
    check_eq("rst_instr", instr, 0);
    check_eq("rst_instr_pc", instr_pc, 0);
    check_eq("rst_fault", fetch_fault, 0);
    reset = 1'b0;
    k_ready = 1'b1; k_lat = 1; k_ir = 1'b1;
    apply_inputs();
    #1;

    // Basic fetch from PC 0
    check_eq("t1_req_valid", imem_req_valid, 1);
    check_eq("t1_req_addr", imem_req_addr, 32'h0);
    step();
    step();
    check_eq("t1_instr_valid", instr_valid, 1);
    check_eq("t1_instr", instr, 32'h0050_0093);
    check_eq("t1_instr_pc", instr_pc, 32'h0);
    check_eq("t1_pc_enable", pc_enable, 1);
    check_eq("t1_pc_next", pc_next, 32'h4);
    step();
    check_eq("t1_next_addr", imem_req_addr, 32'h4);

    // Decode stall
    k_ir = 1'b0;
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      check_eq("t2_instr_valid", instr_valid, 1);
      check_eq("t2_instr", instr, mem_word(32'h4));
      check_eq("t2_pc_enable", pc_enable, 0);
      check_eq("t2_req_valid", imem_req_valid, 0);
      step();
    end
    k_ir = 1'b1;
    step();
    step();
    check_eq("t2_next_addr", imem_req_addr, 32'h8);

    // Redirect while waiting, response arrives two cycles later
    k_lat = 3; k_redir = 1'b1; k_target = 32'h100;
    step();
    check_eq("t3_pc_enable", pc_enable, 1);
    check_eq("t3_pc_next", pc_next, 32'h100);
    k_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      check_eq("t3_no_instr", instr_valid, 0);
    end
    step();
    check_eq("t3_req_valid", imem_req_valid, 1);
    check_eq("t3_req_addr", imem_req_addr, 32'h100);

    // Misaligned PC
    k_redir = 1'b1; k_target = 32'h102;
    step();
    check_eq("t4_redir_req", imem_req_valid, 0);
    check_eq("t4_pc_next", pc_next, 32'h102);
    step();
    check_eq("t4_no_req", imem_req_valid, 0);
    check_eq("t4_fault_pre", fetch_fault, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq("t4_fault", fetch_fault, 1);
      check_eq("t4_fault_no_req", imem_req_valid, 0);
    end
    k_ready = 1'b1; k_lat = 1; k_redir = 1'b1; k_target = 32'h200;
    step();
    check_eq("t4_clr_pc_enable", pc_enable, 1);
    check_eq("t4_clr_pc_next", pc_next, 32'h200);
    step();
    check_eq("t4_clr_fault", fetch_fault, 0);
    check_eq("t4_clr_req", imem_req_valid, 1);
    check_eq("t4_clr_addr", imem_req_addr, 32'h200);

    // PC wrap-around
    step();
    step();
    k_redir = 1'b1; k_target = 32'hFFFF_FFFC;
    step();
    step();
    check_eq("t5_req_addr", imem_req_addr, 32'hFFFF_FFFC);
    step();
    step();
    check_eq("t5_pc_enable", pc_enable, 1);
    check_eq("t5_pc_next", pc_next, 32'h0);
    step();
    check_eq("t5_wrap_addr", imem_req_addr, 32'h0);

    // Reset during WAIT
    k_lat = 3;
    step();
    reset = 1'b1;
    #1;
    check_eq("t6_pc_enable", pc_enable, 0);
    check_eq("t6_req_valid", imem_req_valid, 0);
    check_eq("t6_instr_valid", instr_valid, 0);
    check_eq("t6_instr", instr, 0);
    check_eq("t6_instr_pc", instr_pc, 0);
    check_eq("t6_fault", fetch_fault, 0);
    clear_models();
    imem_rsp_valid = 1'b0;
    redirect_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    pc_n = pc;
    #1;
    check_eq("t6_fresh_req", imem_req_valid, 1);
    check_eq("t6_fresh_addr", imem_req_addr, pc);

    // Randomized traffic
    rnd = 1'b1;
    repeat (2500) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
